// File: rtl/viterbi_obs_sequencer.sv
// Framing stage for the Viterbi core: buffers one observation frame, then replays it
// as start/obs_valid pulses at one symbol per two cycles and waits for the core's done.
module viterbi_obs_sequencer #(
  parameter int unsigned OBS_W   = 2,
  parameter int unsigned LEN_W   = 3,
  parameter int unsigned MAX_LEN = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OBS_W-1:0] s_obs,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic             v_start,
  output logic [LEN_W-1:0] v_length,
  output logic [OBS_W-1:0] v_obs,
  output logic             v_obs_valid,
  input  logic             v_done,
  output logic             frame_done,
  output logic             trunc_err
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);

  typedef enum logic [2:0] {FILL, DROP, START, FEED, WAIT} state_t;

  state_t           state, state_d;
  logic [LEN_W-1:0] cnt, cnt_d, idx, idx_d, cnt_inc;
  logic             phase, phase_d;
  logic [OBS_W-1:0] mem [MAX_LEN];
  logic             accept;

  logic             s_ready_d, v_start_d, v_obs_valid_d, frame_done_d, trunc_err_d;
  logic [LEN_W-1:0] v_length_d;
  logic [OBS_W-1:0] v_obs_d;

  assign accept  = s_valid && s_ready;
  assign cnt_inc = cnt + ONE_L;

  // Frame buffer; only written while filling, contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (!rst && state == FILL && accept) mem[cnt] <= s_obs;
  end

  // Next-state and next-output logic; outputs are registered from these values
  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    idx_d         = idx;
    phase_d       = phase;
    v_start_d     = 1'b0;
    v_obs_valid_d = 1'b0;
    frame_done_d  = 1'b0;
    trunc_err_d   = 1'b0;
    v_length_d    = v_length;
    v_obs_d       = v_obs;
    case (state)
      FILL: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (s_last) begin
            state_d    = START;
            v_start_d  = 1'b1;
            v_length_d = cnt_inc;
            // symbol 0 is being written this cycle when the frame has length 1
            v_obs_d    = (cnt == '0) ? s_obs : mem[0];
          end else if (cnt_inc == MAX_LEN_L) begin
            trunc_err_d = 1'b1;
            state_d     = DROP;
          end
        end
      end
      DROP: begin
        if (accept && s_last) begin
          state_d    = START;
          v_start_d  = 1'b1;
          v_length_d = cnt;
          v_obs_d    = mem[0];
        end
      end
      START: begin
        idx_d   = ONE_L;
        phase_d = 1'b0;
        state_d = (cnt == ONE_L) ? WAIT : FEED;
      end
      FEED: begin
        if (!phase) begin
          v_obs_valid_d = 1'b1;
          v_obs_d       = mem[idx];
          idx_d         = idx + ONE_L;
          phase_d       = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (idx == cnt) state_d = WAIT;
        end
      end
      WAIT: begin
        if (v_done) begin
          state_d      = FILL;
          frame_done_d = 1'b1;
          cnt_d        = '0;
        end
      end
      default: state_d = FILL;
    endcase
    s_ready_d = (state_d == FILL) || (state_d == DROP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      cnt         <= '0;
      idx         <= '0;
      phase       <= 1'b0;
      s_ready     <= 1'b0;
      v_start     <= 1'b0;
      v_obs_valid <= 1'b0;
      v_obs       <= '0;
      v_length    <= '0;
      frame_done  <= 1'b0;
      trunc_err   <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      idx         <= idx_d;
      phase       <= phase_d;
      s_ready     <= s_ready_d;
      v_start     <= v_start_d;
      v_obs_valid <= v_obs_valid_d;
      v_obs       <= v_obs_d;
      v_length    <= v_length_d;
      frame_done  <= frame_done_d;
      trunc_err   <= trunc_err_d;
    end
  end

endmodule

// File: tb/tb_viterbi_obs_sequencer.sv
// Directed bench for viterbi_obs_sequencer with cycle-exact expectations per scenario.
module tb_viterbi_obs_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] s_obs;
  logic       s_valid, s_last, s_ready;
  logic       v_start, v_obs_valid, v_done, frame_done, trunc_err;
  logic [2:0] v_length;
  logic [1:0] v_obs;

  int passed = 0;
  int total  = 0;

  viterbi_obs_sequencer #(.OBS_W(2), .LEN_W(3), .MAX_LEN(7)) dut (
    .clk(clk), .rst(rst), .s_obs(s_obs), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .v_start(v_start), .v_length(v_length), .v_obs(v_obs),
    .v_obs_valid(v_obs_valid), .v_done(v_done), .frame_done(frame_done),
    .trunc_err(trunc_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] sym, input logic last);
    s_valid = 1'b1; s_obs = sym; s_last = last;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_obs = 2'd0; v_done = 1'b0;
    tick(); tick(); tick();
    total++;
    if ({s_ready, v_start, v_obs_valid, v_obs, v_length, frame_done, trunc_err} !== 10'd0)
      $display("FAIL reset_outputs got=%b exp=0", {s_ready, v_start, v_obs_valid, v_obs, v_length, frame_done, trunc_err});
    else passed++;
    rst = 1'b0;
    tick();
    total++;
    if (s_ready !== 1'b1) $display("FAIL reset_release_ready got=%b exp=1", s_ready); else passed++;
  endtask

  task automatic test_basic();
    logic [1:0] syms [5];
    syms = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
    for (int i = 0; i < 5; i++) send(syms[i], i == 4);
    total++;
    if ({v_start, v_obs, v_length, s_ready} !== {1'b1, 2'd0, 3'd5, 1'b0})
      $display("FAIL basic_start got=%b exp=%b", {v_start, v_obs, v_length, s_ready}, {1'b1, 2'd0, 3'd5, 1'b0});
    else passed++;
    for (int k = 1; k < 5; k++) begin
      tick();
      total++;
      if ({v_start, v_obs_valid} !== 2'b00) $display("FAIL basic_gap%0d got=%b exp=00", k, {v_start, v_obs_valid});
      else passed++;
      tick();
      total++;
      if ({v_obs_valid, v_obs} !== {1'b1, syms[k]})
        $display("FAIL basic_pulse%0d got=%b exp=%b", k, {v_obs_valid, v_obs}, {1'b1, syms[k]});
      else passed++;
    end
    tick(); tick();
    total++;
    if ({frame_done, v_length, s_ready} !== {1'b0, 3'd5, 1'b0})
      $display("FAIL basic_wait got=%b exp=%b", {frame_done, v_length, s_ready}, {1'b0, 3'd5, 1'b0});
    else passed++;
    tick();
    v_done = 1'b1;
    tick();
    v_done = 1'b0;
    total++;
    if ({frame_done, s_ready} !== 2'b11) $display("FAIL basic_done got=%b exp=11", {frame_done, s_ready});
    else passed++;
    tick();
    total++;
    if (frame_done !== 1'b0) $display("FAIL basic_done_pulse got=%b exp=0", frame_done); else passed++;
  endtask

  task automatic test_single();
    send(2'd2, 1'b1);
    total++;
    if ({v_start, v_obs, v_length} !== {1'b1, 2'd2, 3'd1})
      $display("FAIL single_start got=%b exp=%b", {v_start, v_obs, v_length}, {1'b1, 2'd2, 3'd1});
    else passed++;
    v_done = 1'b1;
    tick();
    total++;
    if ({v_obs_valid, frame_done} !== 2'b00) $display("FAIL single_s1 got=%b exp=00", {v_obs_valid, frame_done});
    else passed++;
    tick();
    v_done = 1'b0;
    total++;
    if ({frame_done, s_ready} !== 2'b11) $display("FAIL single_done got=%b exp=11", {frame_done, s_ready});
    else passed++;
    tick();
  endtask

  task automatic test_trunc();
    logic [1:0] syms [9];
    syms = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int i = 0; i < 9; i++) begin
      total++;
      if (s_ready !== 1'b1) $display("FAIL trunc_ready%0d got=%b exp=1", i, s_ready); else passed++;
      send(syms[i], i == 8);
      total++;
      if (trunc_err !== (i == 6)) $display("FAIL trunc_err%0d got=%b exp=%b", i, trunc_err, i == 6);
      else passed++;
    end
    total++;
    if ({v_start, v_obs, v_length} !== {1'b1, 2'd1, 3'd7})
      $display("FAIL trunc_start got=%b exp=%b", {v_start, v_obs, v_length}, {1'b1, 2'd1, 3'd7});
    else passed++;
    for (int k = 1; k < 7; k++) begin
      tick(); tick();
      total++;
      if ({v_obs_valid, v_obs} !== {1'b1, syms[k]})
        $display("FAIL trunc_pulse%0d got=%b exp=%b", k, {v_obs_valid, v_obs}, {1'b1, syms[k]});
      else passed++;
    end
    tick();
    v_done = 1'b1;
    tick();
    v_done = 1'b0;
    total++;
    if ({frame_done, trunc_err} !== 2'b10) $display("FAIL trunc_done got=%b exp=10", {frame_done, trunc_err});
    else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic ready_leak;
    s_valid = 1'b1; s_obs = 2'd1; s_last = 1'b0;
    tick();
    s_obs = 2'd2; s_last = 1'b1;
    tick();
    s_obs = 2'd3; s_last = 1'b1;
    total++;
    if ({v_start, v_obs, v_length} !== {1'b1, 2'd1, 3'd2})
      $display("FAIL b2b_start_a got=%b exp=%b", {v_start, v_obs, v_length}, {1'b1, 2'd1, 3'd2});
    else passed++;
    ready_leak = s_ready;
    tick();
    ready_leak |= s_ready;
    tick();
    ready_leak |= s_ready;
    total++;
    if ({v_obs_valid, v_obs} !== {1'b1, 2'd2})
      $display("FAIL b2b_pulse_a got=%b exp=%b", {v_obs_valid, v_obs}, {1'b1, 2'd2});
    else passed++;
    tick();
    ready_leak |= s_ready;
    v_done = 1'b1;
    total++;
    if (ready_leak !== 1'b0) $display("FAIL b2b_ready_inflight got=%b exp=0", ready_leak); else passed++;
    tick();
    v_done = 1'b0;
    total++;
    if ({frame_done, s_ready, v_start} !== 3'b110)
      $display("FAIL b2b_done_a got=%b exp=110", {frame_done, s_ready, v_start});
    else passed++;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    total++;
    if ({v_start, v_obs, v_length, s_ready} !== {1'b1, 2'd3, 3'd1, 1'b0})
      $display("FAIL b2b_start_b got=%b exp=%b", {v_start, v_obs, v_length, s_ready}, {1'b1, 2'd3, 3'd1, 1'b0});
    else passed++;
    v_done = 1'b1;
    tick(); tick();
    v_done = 1'b0;
    total++;
    if ({frame_done, v_start} !== 2'b10) $display("FAIL b2b_done_b got=%b exp=10", {frame_done, v_start});
    else passed++;
    tick();
  endtask

  task automatic test_done_early();
    logic early;
    send(2'd1, 1'b0); send(2'd2, 1'b0); send(2'd3, 1'b1);
    v_done = 1'b1;
    early = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      early |= frame_done;
    end
    total++;
    if (early !== 1'b0) $display("FAIL early_done_ignored got=%b exp=0", early); else passed++;
    tick();
    v_done = 1'b0;
    total++;
    if ({frame_done, s_ready, v_obs} !== {1'b1, 1'b1, 2'd3})
      $display("FAIL early_done got=%b exp=%b", {frame_done, s_ready, v_obs}, {1'b1, 1'b1, 2'd3});
    else passed++;
    tick();
  endtask

  task automatic test_mid_reset();
    logic stray;
    send(2'd0, 1'b0); send(2'd1, 1'b0); send(2'd2, 1'b0); send(2'd3, 1'b0); send(2'd0, 1'b1);
    tick(); tick();
    total++;
    if ({v_obs_valid, v_obs} !== {1'b1, 2'd1})
      $display("FAIL rst_pre_pulse got=%b exp=%b", {v_obs_valid, v_obs}, {1'b1, 2'd1});
    else passed++;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({v_obs_valid, v_start, s_ready, frame_done, v_length, v_obs} !== 9'd0)
      $display("FAIL rst_cleared got=%b exp=0", {v_obs_valid, v_start, s_ready, frame_done, v_length, v_obs});
    else passed++;
    tick();
    total++;
    if (s_ready !== 1'b1) $display("FAIL rst_ready got=%b exp=1", s_ready); else passed++;
    stray = v_obs_valid | v_start;
    for (int c = 0; c < 4; c++) begin
      tick();
      stray |= v_obs_valid | v_start;
    end
    total++;
    if (stray !== 1'b0) $display("FAIL rst_no_stray got=%b exp=0", stray); else passed++;
    send(2'd3, 1'b0); send(2'd1, 1'b1);
    total++;
    if ({v_start, v_obs, v_length} !== {1'b1, 2'd3, 3'd2})
      $display("FAIL rst_next_start got=%b exp=%b", {v_start, v_obs, v_length}, {1'b1, 2'd3, 3'd2});
    else passed++;
    tick(); tick();
    total++;
    if ({v_obs_valid, v_obs} !== {1'b1, 2'd1})
      $display("FAIL rst_next_pulse got=%b exp=%b", {v_obs_valid, v_obs}, {1'b1, 2'd1});
    else passed++;
    tick();
    v_done = 1'b1;
    tick();
    v_done = 1'b0;
    total++;
    if (frame_done !== 1'b1) $display("FAIL rst_next_done got=%b exp=1", frame_done); else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_trunc();
    test_back_to_back();
    test_done_early();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

endmodule
